// File: rtl/cpu_run_ctrl.sv
// Run controller for single_cycle_cpu: streams a program into imem,
// runs the CPU until a halt address or cycle limit, captures x31.
module cpu_run_ctrl #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int CYC_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [31:0]       host_data,
  input  logic              host_last,
  input  logic              start,
  input  logic              clear,
  input  logic [63:0]       halt_pc,
  input  logic [CYC_W-1:0]  cycle_limit,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              cpu_en,
  input  logic [63:0]       cpu_pc,
  input  logic [63:0]       debug_out,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [63:0]       result,
  output logic [CYC_W-1:0]  cycles,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W:0] LAST = FULL - 1'b1;

  state_t           state;
  state_t           state_nx;
  logic [CYC_W-1:0] limit;
  logic             lim_on;
  logic             at_halt;
  logic             at_limit;
  logic             beat;
  logic             wr;
  logic             go_run;
  logic             go_done;

  assign lim_on   = limit != '0;
  assign at_halt  = cpu_pc == halt_pc;
  assign at_limit = lim_on && (cycles == limit);

  assign host_ready = !rst
                   && (state == S_IDLE || state == S_LOAD)
                   && (load_count < FULL);
  assign beat = host_valid && host_ready;

  always_comb begin
    state_nx = state;
    cpu_rst  = 1'b1;
    cpu_en   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (beat)
          state_nx = host_last ? S_READY : S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
        if (clear)
          state_nx = S_IDLE;
        else if (beat && (host_last || load_count == LAST))
          state_nx = S_READY;
      end
      S_READY: begin
        if (clear)
          state_nx = S_IDLE;
        else if (start)
          state_nx = S_RUN;
      end
      S_RUN: begin
        cpu_rst = 1'b0;
        busy    = 1'b1;
        cpu_en  = !at_halt && (!lim_on || cycles < limit);
        if (at_halt || at_limit)
          state_nx = S_DONE;
      end
      S_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
        if (clear)
          state_nx = S_IDLE;
        else if (start)
          state_nx = S_READY;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // a clear in LOAD discards the beat it coincides with
  assign wr      = beat && (state_nx != S_IDLE);
  assign go_run  = (state == S_READY) && (state_nx == S_RUN);
  assign go_done = (state == S_RUN) && (state_nx == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      load_count <= '0;
      limit      <= '0;
      cycles     <= '0;
      timeout    <= 1'b0;
      result     <= '0;
    end else begin
      state   <= state_nx;
      imem_we <= wr;
      if (wr) begin
        imem_waddr <= load_count[ADDR_W-1:0];
        imem_wdata <= host_data;
      end
      if (state_nx == S_IDLE)
        load_count <= '0;
      else if (wr)
        load_count <= load_count + 1'b1;
      if (go_run) begin
        limit   <= cycle_limit;
        cycles  <= '0;
        timeout <= 1'b0;
      end else if (cpu_en && cycles != '1) begin
        cycles <= cycles + 1'b1;
      end
      // CPU is frozen this cycle, so debug_out is stable
      if (go_done) begin
        result  <= debug_out;
        timeout <= !at_halt;
      end
    end
  end

endmodule
